tcb_vip_memory_responder: RTL and testbench

//  TCB subordinate VIP: the responding end of the bus, the counterpart of the protocol checker on the manager side.

---
 rtl/tcb_vip_memory_responder.sv | 127 ++++++++++++
 tb/tb_tcb_vip_memory_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tcb_vip_memory_responder.sv
// TCB subordinate memory model: byte-enabled memory behind a TCB request port.
// Latency: read data / error presented DLY cycles after the transfer cycle, one response per transfer, in order.
// Backpressure: registered rdy; LFSR-driven stalls, never more than MAX_STL consecutive stall cycles.
module tcb_vip_memory_responder #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned SIZE     = 4096,
    parameter int unsigned DLY      = 1,
    parameter bit          STALL_EN = 1'b1,
    parameter int unsigned MAX_STL  = 3,
    parameter logic [15:0] SEED     = 16'hACE1,
    localparam int unsigned BW      = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tcb_vld,
    output logic          tcb_rdy,
    input  logic          tcb_req_wen,
    input  logic [AW-1:0] tcb_req_adr,
    input  logic [BW-1:0] tcb_req_ben,
    input  logic [DW-1:0] tcb_req_wdt,
    output logic [DW-1:0] tcb_rsp_rdt,
    output logic          tcb_rsp_err,
    output logic [31:0]   cnt_wr,
    output logic [31:0]   cnt_rd
);

    localparam int unsigned DEPTH = SIZE / BW;
    localparam int unsigned LB    = $clog2(BW);
    localparam int unsigned LS    = $clog2(SIZE);
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]  mem [DEPTH];
    logic [15:0]    lfsr;
    logic [3:0]     stl_cnt;
    logic [3:0]     stl_nxt;
    logic           trn;
    logic           stall;
    logic           in_range;
    logic [IW-1:0]  idx;
    logic [DW-1:0]  rdt_in;
    logic           err_in;
    logic [DW-1:0]  rdt_pipe [DLY];
    logic [DLY-1:0] err_pipe;

    assign trn      = tcb_vld & tcb_rdy & ~rst;
    assign stall    = tcb_vld & ~tcb_rdy;
    assign in_range = (tcb_req_adr >> LS) == '0;
    assign idx      = IW'(tcb_req_adr >> LB);

    always_comb begin
        stl_nxt = stl_cnt;
        if (trn) begin
            stl_nxt = '0;
        end else if (stall && (stl_cnt != 4'(MAX_STL))) begin
            stl_nxt = stl_cnt + 4'd1;
        end
    end

    // Forcing on the upcoming stall count (not the registered one) keeps a stall run at MAX_STL cycles at most.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcb_rdy <= 1'b0;
            lfsr    <= SEED;
            stl_cnt <= '0;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            stl_cnt <= stl_nxt;
            tcb_rdy <= STALL_EN ? (lfsr[0] | (stl_nxt == 4'(MAX_STL))) : 1'b1;
        end
    end

    // Memory content deliberately survives reset.
    always_ff @(posedge clk) begin
        if (trn && tcb_req_wen && in_range) begin
            for (int i = 0; i < int'(BW); i++) begin
                if (tcb_req_ben[i]) begin
                    mem[idx][8*i +: 8] <= tcb_req_wdt[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdt_in = '0;
        err_in = 1'b0;
        if (trn) begin
            err_in = ~in_range;
            if (!tcb_req_wen && in_range) begin
                rdt_in = mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DLY); i++) begin
                rdt_pipe[i] <= '0;
            end
            err_pipe <= '0;
        end else begin
            rdt_pipe[0] <= rdt_in;
            err_pipe[0] <= err_in;
            for (int i = 1; i < int'(DLY); i++) begin
                rdt_pipe[i] <= rdt_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
            end
        end
    end

    assign tcb_rsp_rdt = rdt_pipe[DLY-1];
    assign tcb_rsp_err = err_pipe[DLY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_wr <= '0;
            cnt_rd <= '0;
        end else if (trn) begin
            if (tcb_req_wen) begin
                cnt_wr <= cnt_wr + 32'd1;
            end else begin
                cnt_rd <= cnt_rd + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_tcb_vip_memory_responder.sv
// Bench: instance A (no stalls, DLY=2) runs a vector table; instance B (LFSR stalls, DLY=3)
// runs back-pressure and mid-operation reset sequences.
module tb_tcb_vip_memory_responder;

    logic        clk;
    logic        a_rst, a_vld, a_rdy, a_wen, a_err;
    logic [31:0] a_adr, a_wdt, a_rdt, a_cnt_wr, a_cnt_rd;
    logic [3:0]  a_ben;
    logic        b_rst, b_vld, b_rdy, b_wen, b_err;
    logic [31:0] b_adr, b_wdt, b_rdt, b_cnt_wr, b_cnt_rd;
    logic [3:0]  b_ben;

    int n_chk  = 0;
    int n_pass = 0;

    tcb_vip_memory_responder #(.DLY(2), .STALL_EN(1'b0)) dut_a (
        .clk(clk), .rst(a_rst), .tcb_vld(a_vld), .tcb_rdy(a_rdy),
        .tcb_req_wen(a_wen), .tcb_req_adr(a_adr), .tcb_req_ben(a_ben), .tcb_req_wdt(a_wdt),
        .tcb_rsp_rdt(a_rdt), .tcb_rsp_err(a_err), .cnt_wr(a_cnt_wr), .cnt_rd(a_cnt_rd)
    );

    tcb_vip_memory_responder #(.DLY(3), .STALL_EN(1'b1), .MAX_STL(3)) dut_b (
        .clk(clk), .rst(b_rst), .tcb_vld(b_vld), .tcb_rdy(b_rdy),
        .tcb_req_wen(b_wen), .tcb_req_adr(b_adr), .tcb_req_ben(b_ben), .tcb_req_wdt(b_wdt),
        .tcb_rsp_rdt(b_rdt), .tcb_rsp_err(b_err), .cnt_wr(b_cnt_wr), .cnt_rd(b_cnt_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
        logic [31:0] rdt;
        bit          err;
    } vec_t;

    vec_t        vt[16];
    logic [31:0] b2b_adr[3];
    logic [31:0] b2b_exp[4];
    logic [31:0] pipe[3];
    logic [31:0] exp_in;
    bit          ok, trn;
    int          op, cyc, run, maxrun, stalls;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] dat(input int i);
        return 32'hC0DE_0000 | 32'(i * 257 + 1);
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer edge.
    task automatic xfer(input bit sel, input bit wen, input logic [31:0] adr,
                        input logic [3:0] ben, input logic [31:0] wdt, output bit done);
        done = 1'b0;
        if (sel) begin b_wen = wen; b_adr = adr; b_ben = ben; b_wdt = wdt; b_vld = 1'b1; end
        else     begin a_wen = wen; a_adr = adr; a_ben = ben; a_wdt = wdt; a_vld = 1'b1; end
        for (int i = 0; i < 32 && !done; i++) begin
            if (sel ? b_rdy : a_rdy) done = 1'b1;
            @(negedge clk);
        end
        if (sel) b_vld = 1'b0; else a_vld = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'h0000_0010, 4'hF,    32'hDEAD_BEEF, 32'h0,          1'b0};
        vt[1]  = '{1'b0, 32'h0000_0010, 4'hF,    32'h0,         32'hDEAD_BEEF,  1'b0};
        vt[2]  = '{1'b1, 32'h0000_0020, 4'hF,    32'h1122_3344, 32'h0,          1'b0};
        vt[3]  = '{1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 32'h0,          1'b0};
        vt[4]  = '{1'b0, 32'h0000_0020, 4'hF,    32'h0,         32'h11BB_33DD,  1'b0};
        vt[5]  = '{1'b1, 32'h0000_0000, 4'hF,    32'h1234_5678, 32'h0,          1'b0};
        vt[6]  = '{1'b0, 32'h0000_1000, 4'hF,    32'h0,         32'h0,          1'b1};
        vt[7]  = '{1'b1, 32'h0000_1000, 4'hF,    32'hFFFF_FFFF, 32'h0,          1'b1};
        vt[8]  = '{1'b0, 32'h0000_0000, 4'hF,    32'h0,         32'h1234_5678,  1'b0};
        vt[9]  = '{1'b0, 32'h0000_0013, 4'hF,    32'h0,         32'hDEAD_BEEF,  1'b0};
        vt[10] = '{1'b1, 32'h0000_0FFC, 4'hF,    32'hCAFE_F00D, 32'h0,          1'b0};
        vt[11] = '{1'b0, 32'h0000_0FFC, 4'hF,    32'h0,         32'hCAFE_F00D,  1'b0};
        vt[12] = '{1'b0, 32'hFFFF_FFFC, 4'hF,    32'h0,         32'h0,          1'b1};
        vt[13] = '{1'b1, 32'h0000_0024, 4'hF,    32'h0000_0055, 32'h0,          1'b0};
        vt[14] = '{1'b1, 32'h0000_0024, 4'h0,    32'hFFFF_FFFF, 32'h0,          1'b0};
        vt[15] = '{1'b0, 32'h0000_0024, 4'hF,    32'h0,         32'h0000_0055,  1'b0};
        b2b_adr[0] = 32'h10; b2b_adr[1] = 32'h20; b2b_adr[2] = 32'h0;
        b2b_exp[0] = 32'hDEAD_BEEF; b2b_exp[1] = 32'h11BB_33DD;
        b2b_exp[2] = 32'h1234_5678; b2b_exp[3] = 32'h0;

        a_rst = 1'b1; a_vld = 1'b0; a_wen = 1'b0; a_adr = '0; a_ben = '0; a_wdt = '0;
        b_rst = 1'b1; b_vld = 1'b0; b_wen = 1'b0; b_adr = '0; b_ben = '0; b_wdt = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_a_rdy", a_rdy, 0);
        chk("rst_a_rdt", a_rdt, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_a_cnt_wr", a_cnt_wr, 0);
        chk("rst_a_cnt_rd", a_cnt_rd, 0);
        chk("rst_b_rdy", b_rdy, 0);
        chk("rst_b_rdt", b_rdt, 0);
        chk("rst_b_cnt_rd", b_cnt_rd, 0);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        chk("a_rdy_after_rst", a_rdy, 1);

        // Vector table on instance A (DLY=2)
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, vt[i].wen, vt[i].adr, vt[i].ben, vt[i].wdt, ok);
            chk($sformatf("vec%0d_handshake", i), ok, 1);
            @(negedge clk);
            chk($sformatf("vec%0d_rdt", i), a_rdt, vt[i].rdt);
            chk($sformatf("vec%0d_err", i), a_err, vt[i].err);
            if (i == 1) begin
                chk("cnt_wr_after_first_pair", a_cnt_wr, 1);
                chk("cnt_rd_after_first_pair", a_cnt_rd, 1);
            end
        end

        // Back-to-back reads on A, one response per cycle in order, then idle zeros
        for (int j = 0; j < 6; j++) begin
            if (j < 3) begin
                a_wen = 1'b0; a_adr = b2b_adr[j]; a_ben = 4'hF; a_vld = 1'b1;
            end else begin
                a_vld = 1'b0;
            end
            if (j >= 2) begin
                chk($sformatf("b2b%0d_rdt", j - 2), a_rdt, b2b_exp[j-2]);
                chk($sformatf("b2b%0d_err", j - 2), a_err, 0);
            end
            @(negedge clk);
        end
        chk("a_cnt_wr_final", a_cnt_wr, 8);
        chk("a_cnt_rd_final", a_cnt_rd, 11);

        // Back-pressure on B: 50 writes then 50 reads with vld held high throughout
        op = 0; cyc = 0; run = 0; maxrun = 0; stalls = 0;
        pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        b_wen = 1'b1; b_adr = 32'h0; b_ben = 4'hF; b_wdt = dat(0); b_vld = 1'b1;
        while (op < 100 && cyc < 3000) begin
            trn = b_rdy;
            if (!trn) begin
                run++; stalls++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            exp_in = (trn && op >= 50) ? dat(op - 50) : 32'h0;
            @(posedge clk);
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = exp_in;
            if (trn) op++;
            @(negedge clk);
            if (op < 100) begin
                b_wen = (op < 50);
                b_adr = 32'(4 * (op % 50));
                b_wdt = (op < 50) ? dat(op) : 32'h0;
            end else begin
                b_vld = 1'b0;
            end
            chk("bp_rdt", b_rdt, pipe[2]);
            chk("bp_err", b_err, 0);
            cyc++;
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = 32'h0;
            @(negedge clk);
            chk("bp_drain_rdt", b_rdt, pipe[2]);
        end
        chk("bp_ops_done", op, 100);
        n_chk++;
        if (maxrun <= 3) n_pass++;
        else $display("FAIL bp_max_stall: got %0d consecutive stall cycles, expected at most 3", maxrun);
        chk("bp_saw_stalls", (stalls > 0), 1);
        chk("bp_cnt_wr", b_cnt_wr, 50);
        chk("bp_cnt_rd", b_cnt_rd, 50);

        // Mid-operation reset on B: read issued, reset next cycle, response must never appear
        xfer(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, ok);
        chk("midrst_handshake", ok, 1);
        b_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_rdt", b_rdt, 0);
            chk("midrst_err", b_err, 0);
        end
        chk("midrst_rdy", b_rdy, 0);
        chk("midrst_cnt_wr", b_cnt_wr, 0);
        chk("midrst_cnt_rd", b_cnt_rd, 0);
        b_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_rdt", b_rdt, 0);
        end
        xfer(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, ok);
        chk("postrst_handshake", ok, 1);
        repeat (2) @(negedge clk);
        chk("postrst_mem_rdt", b_rdt, dat(16));
        chk("postrst_mem_err", b_err, 0);
        chk("postrst_cnt_rd", b_cnt_rd, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
